fast_sqrt_seq: RTL and testbench



---
 rtl/fsqrt_pkg.sv | 28 ++
 rtl/floating_adder.sv | 38 +++
 rtl/floating_multiplication.sv | 24 ++
 rtl/fsqrt_classify.sv | 20 ++
 rtl/fast_sqrt_seq.sv | 73 +++++++
 tb/tb_fast_sqrt_seq.sv | 137 +++++++++++++
 6 files changed

// File: rtl/fsqrt_pkg.sv
// fsqrt_pkg: shared constants, state encoding and input class type for fast_sqrt_seq
package fsqrt_pkg;
  localparam logic [31:0] MAGIC_RSQRT = 32'h5f3759df;
  localparam logic [31:0] FP_HALF = 32'h3f000000;
  localparam logic [31:0] FP_1P5 = 32'h3fc00000;
  localparam logic [31:0] FP_QNAN = 32'h7fc00000;
  localparam logic [31:0] FP_PINF = 32'h7f800000;
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    HALF = 4'd1,
    SQ = 4'd2,
    MUL2 = 4'd3,
    SUB = 4'd4,
    UPD = 4'd5,
    LATCH = 4'd6,
    FINAL = 4'd7,
    RESULT = 4'd8
  } state_t;
  typedef struct packed {
    logic zero;
    logic denorm;
    logic neg;
    logic nan;
    logic pinf;
    logic normal;
  } cls_t;
  localparam cls_t CLS_NORMAL = 6'b000001;
endpackage

// File: rtl/floating_adder.sv
// floating_adder: single-precision add/subtract, round-to-nearest-even, flush-to-zero, 1-clk registered
module floating_adder (
  input logic clk,
  input logic [31:0] a,
  input logic [31:0] b,
  output logic [31:0] result
);
  logic [31:0] big, sml;
  logic [7:0] d;
  logic [26:0] mb, ms;
  logic [27:0] sum;
  logic [25:0] norm;
  logic [4:0] lz;
  logic [22:0] mant;
  logic [23:0] mr;
  logic [9:0] e;
  logic ge, sub, rnd;
  always_comb begin
    ge = a[30:0] >= b[30:0];
    big = ge ? a : b;
    sml = ge ? b : a;
    sub = a[31] ^ b[31];
    d = big[30:23] - sml[30:23];
    mb = big[30:23] == 8'd0 ? 27'd0 : {1'b1, big[22:0], 3'b0};
    ms = sml[30:23] == 8'd0 ? 27'd0 : {1'b1, sml[22:0], 3'b0} >> d;
    sum = sub ? {1'b0, mb} - {1'b0, ms} : {1'b0, mb} + {1'b0, ms};
    lz = 5'd0;
    for (int i = 0; i < 27; i++) lz = sum[i] ? 5'(26 - i) : lz;
    norm = sum[25:0] << lz;
    mant = sum[27] ? sum[26:4] : norm[25:3];
    rnd = sum[27] ? sum[3] && (|sum[2:0] || sum[4]) : norm[2] && (|norm[1:0] || norm[3]);
    mr = {1'b0, mant} + 24'(rnd);
    e = 10'(big[30:23]) + (sum[27] ? 10'd1 : -10'(lz)) + 10'(mr[23]);
  end
  always_ff @(posedge clk)
    result <= sum == 28'd0 || e[9] || e == 10'd0 ? 32'd0
            : e >= 10'd255 ? {big[31], 8'hff, 23'd0} : {big[31], e[7:0], mr[22:0]};
endmodule

// File: rtl/floating_multiplication.sv
// floating_multiplication: single-precision multiply, round-to-nearest-even, flush-to-zero, 1-clk registered
module floating_multiplication (
  input logic clk,
  input logic [31:0] a,
  input logic [31:0] b,
  output logic [31:0] result
);
  logic [47:0] p;
  logic [22:0] mant;
  logic [23:0] mr;
  logic [9:0] e;
  logic rnd, s;
  always_comb begin
    s = a[31] ^ b[31];
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    mant = p[47] ? p[46:24] : p[45:23];
    rnd = p[47] ? p[23] && (|p[22:0] || p[24]) : p[22] && (|p[21:0] || p[23]);
    mr = {1'b0, mant} + 24'(rnd);
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + 10'(p[47]) + 10'(mr[23]);
  end
  always_ff @(posedge clk)
    result <= a[30:23] == 8'd0 || b[30:23] == 8'd0 || e[9] || e == 10'd0 ? {s, 31'd0}
            : e >= 10'd255 ? {s, 8'hff, 23'd0} : {s, e[7:0], mr[22:0]};
endmodule

// File: rtl/fsqrt_classify.sv
// fsqrt_classify: decodes an IEEE-754 single into special/normal classes and the bypass result
module fsqrt_classify import fsqrt_pkg::*; (
  input logic [31:0] x,
  output cls_t cls,
  output logic [31:0] bypass
);
  logic ez, ef, mz;
  always_comb begin
    ez = x[30:23] == 8'h00;
    ef = x[30:23] == 8'hff;
    mz = x[22:0] == 23'd0;
    cls.zero = ez && mz;
    cls.denorm = ez && !mz;
    cls.nan = ef && !mz;
    cls.pinf = ef && mz && !x[31];
    cls.neg = x[31] && !ez && !(ef && !mz);
    cls.normal = !ez && !ef && !x[31];
    bypass = cls.zero ? x : cls.denorm ? 32'd0 : cls.pinf ? FP_PINF : FP_QNAN;
  end
endmodule

// File: rtl/fast_sqrt_seq.sv
// fast_sqrt_seq: sequential sqrt as x*rsqrt(x) with magic seed, Newton steps on one shared mul and adder
module fast_sqrt_seq import fsqrt_pkg::*; #(
  parameter int ITERS = 3
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [31:0] x_in,
  output logic busy,
  output logic done,
  output logic [31:0] y_out,
  output logic special
);
  state_t state;
  cls_t cls;
  logic [31:0] bypass, byp, x, y, h, mul_a, mul_b, mul_out, add_out;
  logic [2:0] cnt;
  logic spec;
  fsqrt_classify u_cls (.x(x_in), .cls(cls), .bypass(bypass));
  floating_multiplication u_mul (.clk(clk), .a(mul_a), .b(mul_b), .result(mul_out));
  floating_adder u_add (.clk(clk), .a(FP_1P5), .b({~mul_out[31], mul_out[30:0]}), .result(add_out));
  always_comb begin
    mul_a = state == HALF || state == FINAL ? x : state == SQ || state == UPD ? y : mul_out;
    mul_b = state == HALF ? FP_HALF : state == SQ ? y : state == MUL2 ? h : state == UPD ? add_out : y;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      special <= 1'b0;
      y_out <= 32'd0;
      cnt <= 3'd0;
      spec <= 1'b0;
    end else begin
      done <= 1'b0;
      special <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          x <= x_in;
          y <= MAGIC_RSQRT - (x_in >> 1);
          byp <= bypass;
          cnt <= 3'd0;
          spec <= cls != CLS_NORMAL;
          state <= cls != CLS_NORMAL ? RESULT : HALF;
        end
        HALF: state <= SQ;
        SQ: begin
          if (cnt == 3'd0) h <= mul_out;
          state <= MUL2;
        end
        MUL2: state <= SUB;
        SUB: state <= UPD;
        UPD: state <= LATCH;
        LATCH: begin
          y <= mul_out;
          cnt <= cnt + 3'd1;
          state <= cnt == 3'(ITERS - 1) ? FINAL : SQ;
        end
        FINAL: state <= RESULT;
        RESULT: begin
          y_out <= spec ? byp : mul_out;
          done <= 1'b1;
          special <= spec;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fast_sqrt_seq.sv
// tb_fast_sqrt_seq: directed and swept self-checking bench for fast_sqrt_seq
module tb_fast_sqrt_seq;
  logic clk = 1'b0;
  logic rst, start, busy, done, special;
  logic [31:0] x_in, y_out;
  int n_assert = 0;
  int n_fail = 0;
  fast_sqrt_seq #(.ITERS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in),
    .busy(busy), .done(done), .y_out(y_out), .special(special)
  );
  always #5 clk = ~clk;
  function automatic int ulp_diff(input logic [31:0] a, input logic [31:0] b);
    int d;
    d = int'(a) - int'(b);
    return d < 0 ? -d : d;
  endfunction
  function automatic logic [31:0] ref_sqrt(input logic [31:0] v);
    logic [63:0] d;
    logic [30:0] em;
    d = {1'b0, 11'(v[30:23]) + 11'd896, v[22:0], 29'd0};
    d = $realtobits($sqrt($bitstoreal(d)));
    em = {8'(d[62:52] - 11'd896), d[51:29]} + 31'(d[28]);
    return {1'b0, em};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (ulp_diff(obs, exp) <= 4) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h within 4 ulp", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [31:0] v, output logic [31:0] y, output int lat, output int bc, output logic sp, output logic bz);
    x_in = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    y = y_out;
    sp = special;
    bz = busy;
  endtask
  logic [31:0] y, v;
  logic sp, bz;
  int lat, bc, n_done;
  logic [31:0] sp_in[6] = '{32'h00000000, 32'h80000000, 32'hbf800000, 32'h7fc00001, 32'h7f800000, 32'h00000001};
  logic [31:0] sp_out[6] = '{32'h00000000, 32'h80000000, 32'h7fc00000, 32'h7fc00000, 32'h7f800000, 32'h00000000};
  initial begin
    rst = 1'b1;
    start = 1'b0;
    x_in = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", y_out, 32'd0);
    chk("rst_special", 32'(special), 32'd0);
    run(32'h40800000, y, lat, bc, sp, bz);
    chk("sqrt4_latency", 32'(lat), 32'd18);
    chk("sqrt4_busy_cycles", 32'(bc), 32'd18);
    chk("sqrt4_busy_at_done", 32'(bz), 32'd0);
    chk("sqrt4_special", 32'(sp), 32'd0);
    chk_ulp("sqrt4", y, 32'h40000000);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    run(32'h41800000, y, lat, bc, sp, bz);
    chk_ulp("sqrt16", y, 32'h40800000);
    run(32'h40000000, y, lat, bc, sp, bz);
    chk("b2b_latency", 32'(lat), 32'd18);
    chk_ulp("sqrt2", y, 32'h3fb504f3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run(sp_in[i], y, lat, bc, sp, bz);
      chk("special_latency", 32'(lat), 32'd1);
      chk("special_flag", 32'(sp), 32'd1);
      chk("special_value", y, sp_out[i]);
    end
    @(negedge clk);
    x_in = 32'h40800000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    y = 32'd0;
    for (int c = 1; c <= 30; c++) begin
      start = c == 3 || c == 10;
      @(negedge clk);
      if (done) begin
        n_done++;
        y = y_out;
        chk("restart_latency", 32'(c), 32'd18);
      end
    end
    start = 1'b0;
    chk("restart_done_count", 32'(n_done), 32'd1);
    chk_ulp("restart_value", y, 32'h40000000);
    x_in = 32'h41100000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_y", y_out, 32'd0);
    n_done = 0;
    repeat (25) begin
      if (done) n_done++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    run(32'h41100000, y, lat, bc, sp, bz);
    chk_ulp("sqrt9", y, 32'h40400000);
    for (int i = 0; i < 1000; i++) begin
      v = {1'b0, 8'($urandom_range(240, 8)), 23'($urandom)};
      run(v, y, lat, bc, sp, bz);
      chk("sweep_latency", 32'(lat), 32'd18);
      chk_ulp("sweep_value", y, ref_sqrt(v));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
